// File: rtl/node_table_writer.sv
// Node-ID table write controller: scans the bank for an ID, appends it when
// absent, and reports the index that holds it.
module node_table_writer #(
    parameter int WORD_WIDTH = 16,
    parameter int MEM_DEPTH  = 64,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tbl_clear,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORD_WIDTH-1:0] in_node_id,
    output logic [ADDR_WIDTH-1:0] mem_index,
    output logic                  mem_wr_en,
    output logic [WORD_WIDTH-1:0] mem_wdata,
    input  logic [WORD_WIDTH-1:0] mem_rdata,
    output logic                  out_valid,
    output logic [ADDR_WIDTH-1:0] out_index,
    output logic                  out_hit,
    output logic                  out_full,
    output logic [ADDR_WIDTH:0]   node_count
);

    localparam int CW = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [WORD_WIDTH-1:0]   id_q;
    logic [CW-1:0]           cnt_q;
    logic [ADDR_WIDTH-1:0]   scan_q;
    logic                    iss_done_q;
    logic                    cmp_vld_q;
    logic [ADDR_WIDTH-1:0]   cmp_idx_q;
    logic                    full_q;
    logic [ADDR_WIDTH-1:0]   oidx_q;
    logic                    ohit_q;
    logic                    ofull_q;

    logic                    cmp_hit;
    logic                    cmp_last;
    logic                    tbl_full;
    logic                    scan_end;

    assign cmp_hit  = cmp_vld_q && (mem_rdata == id_q);
    assign cmp_last = cmp_vld_q && ({1'b0, cmp_idx_q} == cnt_q - CW'(1));
    assign tbl_full = (cnt_q == CW'(MEM_DEPTH));
    assign scan_end = ({1'b0, scan_q} == cnt_q - CW'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid && !tbl_clear) begin
                    state_d = (cnt_q == '0) ? WRITE : SCAN;
                end
            end
            SCAN: begin
                if (cmp_hit) begin
                    state_d = RESP;
                end else if (cmp_last) begin
                    state_d = WRITE;
                end
            end
            WRITE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A full-table miss still passes through WRITE (write suppressed) so
    // every miss has the same accept-to-result latency.
    always_comb begin
        in_ready  = (state_q == IDLE) && !tbl_clear;
        out_valid = (state_q == RESP);
        mem_wr_en = (state_q == WRITE) && !full_q;
        mem_index = '0;
        mem_wdata = '0;
        if (state_q == SCAN) begin
            mem_index = scan_q;
        end else if (mem_wr_en) begin
            mem_index = cnt_q[ADDR_WIDTH-1:0];
            mem_wdata = id_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            id_q       <= '0;
            cnt_q      <= '0;
            scan_q     <= '0;
            iss_done_q <= 1'b0;
            cmp_vld_q  <= 1'b0;
            cmp_idx_q  <= '0;
            full_q     <= 1'b0;
            oidx_q     <= '0;
            ohit_q     <= 1'b0;
            ofull_q    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (tbl_clear) begin
                        cnt_q <= '0;
                    end else if (in_valid) begin
                        id_q       <= in_node_id;
                        scan_q     <= '0;
                        iss_done_q <= 1'b0;
                        cmp_vld_q  <= 1'b0;
                        full_q     <= 1'b0;
                    end
                end
                SCAN: begin
                    cmp_vld_q <= !iss_done_q;
                    cmp_idx_q <= scan_q;
                    if (!iss_done_q) begin
                        if (scan_end) begin
                            iss_done_q <= 1'b1;
                        end else begin
                            scan_q <= scan_q + 1'b1;
                        end
                    end
                    if (cmp_hit) begin
                        oidx_q  <= cmp_idx_q;
                        ohit_q  <= 1'b1;
                        ofull_q <= 1'b0;
                    end else if (cmp_last && tbl_full) begin
                        full_q <= 1'b1;
                    end
                end
                WRITE: begin
                    ohit_q  <= 1'b0;
                    ofull_q <= full_q;
                    oidx_q  <= full_q ? '0 : cnt_q[ADDR_WIDTH-1:0];
                    if (!full_q && !tbl_full) begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_index  = oidx_q;
    assign out_hit    = ohit_q;
    assign out_full   = ofull_q;
    assign node_count = cnt_q;

endmodule

// File: tb/tb_node_table_writer.sv
// Directed bench for node_table_writer with a bank model and a
// list-based table model that predicts index, hit/full, and latency.
module tb_node_table_writer;

    localparam int WW = 16;
    localparam int MD = 64;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tbl_clear = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [WW-1:0] in_node_id = '0;
    logic [AW-1:0] mem_index;
    logic          mem_wr_en;
    logic [WW-1:0] mem_wdata;
    logic [WW-1:0] mem_rdata;
    logic          out_valid;
    logic [AW-1:0] out_index;
    logic          out_hit;
    logic          out_full;
    logic [AW:0]   node_count;

    node_table_writer #(.WORD_WIDTH(WW), .MEM_DEPTH(MD), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .tbl_clear  (tbl_clear),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_node_id (in_node_id),
        .mem_index  (mem_index),
        .mem_wr_en  (mem_wr_en),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .out_valid  (out_valid),
        .out_index  (out_index),
        .out_hit    (out_hit),
        .out_full   (out_full),
        .node_count (node_count)
    );

    always #5 clk = ~clk;

    // Bank: synchronous write, one-cycle registered read.
    logic [WW-1:0] bank [MD];
    initial begin
        for (int i = 0; i < MD; i++) bank[i] = '1;
        mem_rdata = '0;
    end
    always @(posedge clk) begin
        if (mem_wr_en) bank[mem_index] <= mem_wdata;
        mem_rdata <= bank[mem_index];
    end

    int errs = 0;
    int checks = 0;

    // Model: ordered list of stored IDs.
    int tbl[$];

    bit wr_ok = 1'b0;
    int exp_wr_idx = 0;
    int exp_wr_data = 0;
    int nwr = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (mem_wr_en) begin
                nwr++;
                chk("write_allowed", 1, int'(wr_ok));
                if (wr_ok) begin
                    chk("wr_index", int'(mem_index), exp_wr_idx);
                    chk("wr_data", int'(mem_wdata), exp_wr_data);
                end
            end
            if (out_hit && out_full) chk("hit_and_full", 1, 0);
        end
    end

    function automatic int lookup(input int id);
        for (int i = 0; i < tbl.size(); i++)
            if (tbl[i] == id) return i;
        return -1;
    endfunction

    task automatic do_req(input int id, input int pin_lat, input int pin_idx);
        int k, e_idx, e_lat, e_wr, lat;
        bit e_hit, e_full, got;
        @(negedge clk);
        chk("out_valid_one_cycle", int'(out_valid), 0);
        k = lookup(id);
        e_hit = (k >= 0);
        e_full = !e_hit && (tbl.size() == MD);
        e_idx = e_hit ? k : (e_full ? 0 : tbl.size());
        e_lat = e_hit ? k + 3 : (tbl.size() == 0 ? 2 : tbl.size() + 3);
        e_wr = (!e_hit && !e_full) ? 1 : 0;
        wr_ok = e_wr[0];
        exp_wr_idx = e_idx;
        exp_wr_data = id;
        nwr = 0;
        in_valid = 1'b1;
        in_node_id = WW'(id);
        #1 chk("in_ready_idle", int'(in_ready), 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 100) begin
            @(negedge clk);
            lat++;
            if (out_valid) got = 1'b1;
        end
        chk("resp_seen", int'(got), 1);
        chk("latency", lat, e_lat);
        chk("out_index", int'(out_index), e_idx);
        chk("out_hit", int'(out_hit), int'(e_hit));
        chk("out_full", int'(out_full), int'(e_full));
        if (e_wr != 0) tbl.push_back(id);
        chk("node_count", int'(node_count), tbl.size());
        chk("write_count", nwr, e_wr);
        if (pin_lat >= 0) chk("pin_latency", lat, pin_lat);
        if (pin_idx >= 0) chk("pin_index", int'(out_index), pin_idx);
        wr_ok = 1'b0;
    endtask

    task automatic do_clear(input bit with_req);
        @(negedge clk);
        tbl_clear = 1'b1;
        in_valid = with_req;
        in_node_id = WW'(7);
        #1 chk("in_ready_clear", int'(in_ready), 0);
        @(posedge clk);
        #1 tbl_clear = 1'b0;
        in_valid = 1'b0;
        tbl.delete();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("clear_no_resp", int'(out_valid), 0);
        end
        chk("clear_count", int'(node_count), 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_count", int'(node_count), 0);
        chk("rst_wr_en", int'(mem_wr_en), 0);
        chk("rst_out_index", int'(out_index), 0);
        chk("rst_mem_index", int'(mem_index), 0);
        chk("rst_hit", int'(out_hit), 0);
        chk("rst_full", int'(out_full), 0);

        do_req(3, 2, 0);
        do_req(15, 4, 1);
        do_req(3, 3, 0);
        chk("pin_count_2", int'(node_count), 2);

        do_clear(1'b0);
        for (int i = 100; i <= 163; i++) do_req(i, -1, -1);
        chk("pin_count_64", int'(node_count), 64);
        do_req(999, 67, 0);
        chk("pin_full", int'(out_full), 1);
        do_req(163, 66, 63);
        do_req(100, 3, 0);

        do_clear(1'b1);
        do_req(15, 2, 0);
        for (int i = 200; i < 209; i++) do_req(i, -1, -1);
        chk("pre_rst_count", int'(node_count), 10);

        @(negedge clk);
        wr_ok = 1'b0;
        nwr = 0;
        in_valid = 1'b1;
        in_node_id = WW'(42);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        tbl.delete();
        @(negedge clk);
        chk("midscan_rst_ready", int'(in_ready), 1);
        chk("midscan_rst_count", int'(node_count), 0);
        chk("midscan_rst_valid", int'(out_valid), 0);
        chk("midscan_rst_wr", int'(mem_wr_en), 0);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            chk("post_rst_idle_valid", int'(out_valid), 0);
        end
        chk("post_rst_writes", nwr, 0);
        do_req(42, 2, 0);
        do_req(15, 4, 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
